// File: rtl/tmr_evt_irq_arbiter_pkg.sv
// Shared SFR layout, event indexing and FSM state type for the timer event IRQ arbiter.
package tmr_evt_irq_arbiter_pkg;

    localparam int unsigned SFR_W = 32;

    localparam int unsigned OFF_EVT_EN   = 0;
    localparam int unsigned OFF_EVT_PEND = 4;
    localparam int unsigned OFF_IRQ_STAT = 8;

    localparam int unsigned EVT_MATCH0  = 0;
    localparam int unsigned EVT_MATCH1  = 1;
    localparam int unsigned EVT_OVF     = 2;
    localparam int unsigned EVT_PER_TMR = 3;

    typedef logic [SFR_W-1:0] evt_en_t;
    typedef logic [SFR_W-1:0] evt_pend_t;

    typedef struct packed {
        logic [15:0] rsvd_hi;
        logic [7:0]  id;
        logic [6:0]  rsvd_lo;
        logic        req;
    } irq_stat_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    function automatic int unsigned src_idx(input int unsigned tmr, input int unsigned evt);
        return EVT_PER_TMR * tmr + evt;
    endfunction

endpackage

// File: rtl/tmr_evt_irq_arbiter_if.sv
// SFR slave bus plus core interrupt handshake of the timer event IRQ arbiter.
interface tmr_evt_irq_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 5
);
    logic [ADDR_WIDTH-1:0] sys_addr;
    logic                  sys_wr_en;
    logic [DATA_WIDTH-1:0] sys_sw_value;
    logic [DATA_WIDTH-1:0] sfr_rd_dout;
    logic                  irq_req;
    logic [ID_WIDTH-1:0]   irq_id;
    logic                  irq_ack;

    modport master (
        output sys_addr, sys_wr_en, sys_sw_value, irq_ack,
        input  sfr_rd_dout, irq_req, irq_id
    );

    modport slave (
        input  sys_addr, sys_wr_en, sys_sw_value, irq_ack,
        output sfr_rd_dout, irq_req, irq_id
    );
endinterface

// File: rtl/tmr_evt_irq_arbiter_rr_arbiter_nbit.sv
// Combinational round-robin select: first set request at or after ptr, wrapping at N.
module rr_arbiter_nbit #(
    parameter int unsigned N  = 12,
    parameter int unsigned IW = 5
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);
    logic [IW:0] pos;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!valid && (|(req & (N'(1) << pos)))) begin
                valid = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/tmr_evt_irq_arbiter.sv
// Latches timer events as pending flags, masks them, and round-robin grants one IRQ to the core.
module tmr_evt_irq_arbiter
    import tmr_evt_irq_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned NUM_TMR    = 4,
    parameter int unsigned ID_WIDTH   = 5
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         sys_clk_en,
    input  logic [EVT_PER_TMR*NUM_TMR-1:0] tmr_evt_in,
    tmr_evt_irq_arbiter_if.slave         bus
);
    localparam int unsigned NUM_SRC = EVT_PER_TMR * NUM_TMR;

    if (NUM_SRC > DATA_WIDTH) begin : g_chk_src_width
        $error("NUM_SRC exceeds DATA_WIDTH");
    end
    if ((1 << ID_WIDTH) < NUM_SRC) begin : g_chk_id_width
        $error("ID_WIDTH too small for NUM_SRC");
    end
    if (ID_WIDTH > 8) begin : g_chk_stat_id
        $error("ID_WIDTH does not fit the IRQ_STAT id field");
    end

    logic [NUM_SRC-1:0]  evt_q, rise, pend, pend_nxt, en;
    logic [NUM_SRC-1:0]  w1c_mask, ack_mask, arb_req;
    logic [ID_WIDTH-1:0] rr_ptr, irq_id_q, arb_idx;
    logic                arb_valid, load_grant, take_ack;
    logic                sel_en, sel_pend, sel_stat;
    arb_state_e          state, state_nxt;
    evt_en_t             en_rd;
    evt_pend_t           pend_rd;
    irq_stat_t           stat_rd;

    assign sel_en   = (bus.sys_addr == ADDR_WIDTH'(BASE_ADDR + OFF_EVT_EN));
    assign sel_pend = (bus.sys_addr == ADDR_WIDTH'(BASE_ADDR + OFF_EVT_PEND));
    assign sel_stat = (bus.sys_addr == ADDR_WIDTH'(BASE_ADDR + OFF_IRQ_STAT));

    assign rise     = tmr_evt_in & ~evt_q;
    assign w1c_mask = (bus.sys_wr_en && sel_pend) ? bus.sys_sw_value[NUM_SRC-1:0] : '0;
    assign ack_mask = take_ack ? (NUM_SRC'(1) << irq_id_q) : '0;
    // OR-ing rise after the clear makes a coincident set win over W1C or ack
    assign pend_nxt = (pend & ~(w1c_mask | ack_mask)) | rise;
    assign arb_req  = pend & en;

    rr_arbiter_nbit #(
        .N  (NUM_SRC),
        .IW (ID_WIDTH)
    ) u_rr (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else if (sys_clk_en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_grant = 1'b0;
        take_ack   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_nxt  = ST_REQ;
                    load_grant = 1'b1;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) begin
                    state_nxt = ST_GAP;
                    take_ack  = 1'b1;
                end
            end
            ST_GAP:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            evt_q    <= '0;
            pend     <= '0;
            en       <= '0;
            irq_id_q <= '0;
            rr_ptr   <= '0;
        end else if (sys_clk_en) begin
            evt_q <= tmr_evt_in;
            pend  <= pend_nxt;
            if (bus.sys_wr_en && sel_en) begin
                en <= bus.sys_sw_value[NUM_SRC-1:0];
            end
            if (load_grant) begin
                irq_id_q <= arb_idx;
            end
            if (take_ack) begin
                rr_ptr <= (irq_id_q == ID_WIDTH'(NUM_SRC - 1)) ? '0 : irq_id_q + 1'b1;
            end
        end
    end

    // irq_req decodes the state flop, so an async reset drops it at once
    assign bus.irq_req = (state == ST_REQ);
    assign bus.irq_id  = irq_id_q;

    always_comb begin
        en_rd         = evt_en_t'(en);
        pend_rd       = evt_pend_t'(pend);
        stat_rd       = '0;
        stat_rd.req   = (state == ST_REQ);
        stat_rd.id    = 8'(irq_id_q);
    end

    assign bus.sfr_rd_dout = ({DATA_WIDTH{sel_en}}   & DATA_WIDTH'(en_rd))
                           | ({DATA_WIDTH{sel_pend}} & DATA_WIDTH'(pend_rd))
                           | ({DATA_WIDTH{sel_stat}} & DATA_WIDTH'(stat_rd));
endmodule
